serial_sub_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit subtraction A − B by reusing a single one-bit subtractor cell, LSB first, one bit per clock. The cell is built from two half subtractors plus a borrow OR. The block accepts operands on a start pulse, steps the cell through every bit position while carrying the borrow in a flip-flop, then publishes the difference and final borrow with a one-cycle done pulse. It sits between a requesting controller and the subtractor datapath. It trades latency for area relative to a parallel ripple subtractor.

---
 rtl/serial_sub_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial subtractor controller. Computes D = A - B (mod 2^WIDTH) by
// stepping one 1-bit subtractor cell, built from two half subtractors and a
// borrow OR, over the operands LSB first, one bit per clock. The borrow is
// carried between bit positions in a flip-flop.
//
// Handshake: an operation is accepted on a rising edge where START=1 and
// BUSY=0. A and B are sampled on that edge only. BUSY stays high from the
// accepting edge until the FIN exit edge. START seen while BUSY=1 is dropped,
// not queued. DONE is a one-cycle pulse. D, BOUT and ZERO become valid in the
// DONE cycle and hold until the next operation completes.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   START      operation request, sampled only while BUSY=0
//   A, B       minuend / subtrahend (WIDTH bits)
//   BUSY       high in RUN and FIN
//   DONE       one-cycle completion pulse
//   D          difference A - B mod 2^WIDTH
//   BOUT       final borrow, 1 iff A < B (unsigned)
//   ZERO       1 iff D == 0
//   state_dbg  current FSM state (IDLE=0, RUN=1, FIN=2)
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             ZERO,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    // One-bit subtractor cell: two half subtractors plus a borrow OR.
    logic cell_a, cell_b;
    logic hs1_d, hs1_b;
    logic cell_d, hs2_b, cell_bout;
    logic last_bit;
    logic [WIDTH-1:0] res_nxt;

    assign cell_a    = sa[0];
    assign cell_b    = sb[0];
    assign hs1_d     = cell_a ^ cell_b;
    assign hs1_b     = ~cell_a & cell_b;
    assign cell_d    = hs1_d ^ borrow;
    assign hs2_b     = ~hs1_d & borrow;
    assign cell_bout = hs1_b | hs2_b;

    // Result fills from the MSB end, so after WIDTH shifts bit 0 sits at [0].
    assign res_nxt  = {cell_d, res[WIDTH-1:1]};
    assign last_bit = (cnt == LAST_CNT);

    assign BUSY      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            BOUT   <= 1'b0;
            ZERO   <= 1'b1;
            DONE   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        sa     <= A;
                        sb     <= B;
                        res    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= res_nxt;
                    borrow <= cell_bout;
                    cnt    <= cnt + CNT_W'(1);
                    // Published outputs only move on the completion edge.
                    if (last_bit) begin
                        D    <= res_nxt;
                        BOUT <= cell_bout;
                        ZERO <= (res_nxt == '0);
                        DONE <= 1'b1;
                    end
                end
                FIN: begin
                    DONE <= 1'b0;
                end
                default: begin
                    DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BOUT;
    logic             ZERO;
    logic [1:0]       state_dbg;

    int total_cnt;
    int fail_cnt;
    logic [WIDTH-1:0] last_d;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .A         (A),
        .B         (B),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .D         (D),
        .BOUT      (BOUT),
        .ZERO      (ZERO),
        .state_dbg (state_dbg)
    );

    // Clock / reset block: 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp)
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one operation and follows it for WIDTH+3 samples taken 1 ns
    // after each rising edge, starting with the accepting edge E0.
    // With noisy=1, A/B are scrambled and START is pulsed during RUN and FIN.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_d, input logic exp_bout,
                          input logic exp_zero, input bit noisy, input string tag);
        int  done_at;
        int  done_n;
        int  busy_n;
        bit  hold_ok;
        @(negedge CLK);
        A     = a;
        B     = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START   = 1'b0;
        done_at = -1;
        done_n  = 0;
        busy_n  = 0;
        hold_ok = 1'b1;
        for (int i = 0; i <= WIDTH + 2; i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #1;
            end
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (i < WIDTH && D !== last_d) hold_ok = 1'b0;
            if (noisy) begin
                A = WIDTH'($urandom_range(0, 255));
                B = WIDTH'($urandom_range(0, 255));
                if (i == WIDTH) START = 1'b1;          // lands on the FIN edge
                else if (i < WIDTH) START = 1'($urandom_range(0, 1));
                else START = 1'b0;
            end
        end
        START = 1'b0;
        check({tag, "_hold"},    32'(hold_ok),  32'd1);
        check({tag, "_done_at"}, 32'(done_at),  32'(WIDTH));
        check({tag, "_done_n"},  32'(done_n),   32'd1);
        check({tag, "_busy_n"},  32'(busy_n),   32'(WIDTH + 1));
        check({tag, "_d"},       32'(D),        32'(exp_d));
        check({tag, "_bout"},    32'(BOUT),     32'(exp_bout));
        check({tag, "_zero"},    32'(ZERO),     32'(exp_zero));
        check({tag, "_idle"},    32'(BUSY),     32'd0);
        last_d = exp_d;
    endtask

    initial begin
        bit saw_done;
        total_cnt = 0;
        fail_cnt  = 0;
        last_d    = '0;
        RST_N     = 1'b1;
        START     = 1'b0;
        A         = '0;
        B         = '0;

        // Asynchronous reset between edges; outputs must respond at once.
        #7;
        RST_N = 1'b0;
        #1;
        check("rst_busy",  32'(BUSY),      32'd0);
        check("rst_done",  32'(DONE),      32'd0);
        check("rst_d",     32'(D),         32'd0);
        check("rst_bout",  32'(BOUT),      32'd0);
        check("rst_zero",  32'(ZERO),      32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, "basic");
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, "under1");
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, "under2");
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, "nounder");
        run_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, "zero");
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1, "ignore");

        // Nothing may start after the ignored START pulses.
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) saw_done = 1'b1;
        end
        check("ignore_no_restart", 32'(saw_done), 32'd0);

        // Reset in the middle of RUN discards the operation.
        @(negedge CLK);
        A     = 8'h80;
        B     = 8'h01;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_done", 32'(DONE), 32'd0);
        check("midrst_d",    32'(D),    32'd0);
        check("midrst_bout", 32'(BOUT), 32'd0);
        check("midrst_zero", 32'(ZERO), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        last_d = '0;
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
